// File: rtl/fv_sb_pkg.sv
// Shared types and constants for the Wolper-legal stimulus source.
// Holds the FSM state encoding and the Galois LFSR tap table.
package fv_sb_pkg;

    localparam int DWIDTH_DEF = 4;
    localparam int CWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Toggle masks for a right-shifting maximal-length Galois LFSR.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/fv_sb_lfsr.sv
// Galois LFSR that steps only when told to; reseeded solely by reset.
module fv_sb_lfsr
    import fv_sb_pkg::*;
#(
    parameter int                 DWIDTH = DWIDTH_DEF,
    parameter logic [DWIDTH-1:0]  SEED   = DWIDTH'(1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              adv,
    output logic [DWIDTH-1:0] state
);

    localparam logic [15:0]       TAPS_ALL = lfsr_taps(DWIDTH);
    localparam logic [DWIDTH-1:0] TAPS     = TAPS_ALL[DWIDTH-1:0];

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEED;
        end else if (adv) begin
            state <= {1'b0, state[DWIDTH-1:1]} ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/fv_sb_wolper_src.sv
// Stimulus source for the Wolper scoreboard: one marker A, optional later
// marker B, all other beats LFSR filler that never collides with a marker.
module fv_sb_wolper_src
    import fv_sb_pkg::*;
#(
    parameter int          DWIDTH    = DWIDTH_DEF,
    parameter int          CWIDTH    = CWIDTH_DEF,
    parameter int unsigned LFSR_SEED = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CWIDTH-1:0] cfg_len,
    input  logic [CWIDTH-1:0] cfg_idx_a,
    input  logic              cfg_two_mark,
    input  logic [CWIDTH-1:0] cfg_idx_b,
    input  logic [DWIDTH-1:0] cfg_mark_a,
    input  logic [DWIDTH-1:0] cfg_mark_b,
    output logic              push_valid,
    input  logic              push_ready,
    output logic [DWIDTH-1:0] push_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [CWIDTH-1:0] beat_cnt
);

    localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);
    localparam logic [DWIDTH-1:0] TWO = DWIDTH'(2);

    state_t            state_q, state_nxt;
    logic [CWIDTH-1:0] len_q, idx_a_q, idx_b_q;
    logic              two_q;
    logic [DWIDTH-1:0] mark_a_q, mark_b_q;
    logic [DWIDTH-1:0] lfsr, filler, payload;
    logic              latch_cfg, set_err, accept, last_beat, cfg_bad;
    logic              is_a, is_b;

    assign cfg_bad = (len_q == '0) || (idx_a_q >= len_q) ||
                     (two_q && ((idx_b_q >= len_q) || (idx_b_q <= idx_a_q) ||
                                (mark_b_q == mark_a_q)));

    assign push_valid = (state_q == SEND);
    assign busy       = (state_q == CHECK) || (state_q == SEND);
    assign done       = (state_q == DONE);
    assign accept     = push_valid && push_ready;
    assign last_beat  = (beat_cnt == len_q - CWIDTH'(1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state_q;
        latch_cfg = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (cfg_bad) begin
                    set_err   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (accept && last_beat) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // NOTE: the latched config copies are reset too, so nothing stale survives an abort.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q    <= '0;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            two_q    <= 1'b0;
            mark_a_q <= '0;
            mark_b_q <= '0;
            cfg_err  <= 1'b0;
            beat_cnt <= '0;
        end else if (latch_cfg) begin
            len_q    <= cfg_len;
            idx_a_q  <= cfg_idx_a;
            idx_b_q  <= cfg_idx_b;
            two_q    <= cfg_two_mark;
            mark_a_q <= cfg_mark_a;
            mark_b_q <= cfg_mark_b;
            cfg_err  <= 1'b0;
            beat_cnt <= '0;
        end else if (set_err) begin
            cfg_err  <= 1'b1;
        end else if (accept && (beat_cnt != len_q)) begin
            beat_cnt <= beat_cnt + CWIDTH'(1);
        end
    end

    // Payload depends only on registered state, so it holds steady across stalls.
    always_comb begin
        is_a = (beat_cnt == idx_a_q);
        is_b = two_q && (beat_cnt == idx_b_q);
        if ((lfsr != mark_a_q) && (lfsr != mark_b_q)) begin
            filler = lfsr;
        end else if (((lfsr ^ ONE) != mark_a_q) && ((lfsr ^ ONE) != mark_b_q)) begin
            filler = lfsr ^ ONE;
        end else begin
            filler = lfsr ^ TWO;
        end
        if (is_a)      payload = mark_a_q;
        else if (is_b) payload = mark_b_q;
        else           payload = filler;
    end

    assign push_data = push_valid ? payload : '0;

    fv_sb_lfsr #(
        .DWIDTH (DWIDTH),
        .SEED   (DWIDTH'(LFSR_SEED))
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .adv   (accept && !is_a && !is_b),
        .state (lfsr)
    );

endmodule

// File: tb/tb_fv_sb_wolper_src.sv
// Self-checking bench for fv_sb_wolper_src: scenario tasks against a
// beat-level reference model driven by a tabulated LFSR sequence.
module tb_fv_sb_wolper_src;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_len = '0, cfg_idx_a = '0, cfg_idx_b = '0;
    logic          cfg_two_mark = 1'b0;
    logic [DW-1:0] cfg_mark_a = '0, cfg_mark_b = '0;
    logic          push_ready = 1'b0;
    logic          push_valid, busy, done, cfg_err;
    logic [DW-1:0] push_data;
    logic [CW-1:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Period-15 sequence of x^4+x^3+1 from seed 1; the model only indexes it.
    logic [3:0] lfsr_seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                  4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    int mdl_pos = 0;

    always #5 clk = ~clk;

    fv_sb_wolper_src #(.DWIDTH(DW), .CWIDTH(CW), .LFSR_SEED(1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_idx_a    (cfg_idx_a),
        .cfg_two_mark (cfg_two_mark),
        .cfg_idx_b    (cfg_idx_b),
        .cfg_mark_a   (cfg_mark_a),
        .cfg_mark_b   (cfg_mark_b),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .beat_cnt     (beat_cnt)
    );

    function automatic logic [3:0] mdl_filler(input logic [3:0] ma, input logic [3:0] mb);
        logic [3:0] l;
        l = lfsr_seq[mdl_pos % 15];
        if (l != ma && l != mb) return l;
        if ((l ^ 4'd1) != ma && (l ^ 4'd1) != mb) return l ^ 4'd1;
        return l ^ 4'd2;
    endfunction

    task automatic apply_cfg(input int len, input int ia, input bit two, input int ib,
                             input logic [3:0] ma, input logic [3:0] mb);
        cfg_len      = CW'(len);
        cfg_idx_a    = CW'(ia);
        cfg_two_mark = two;
        cfg_idx_b    = CW'(ib);
        cfg_mark_a   = ma;
        cfg_mark_b   = mb;
    endtask

    // mode: 0 = ready always high, 1 = ready 1,0,0 repeating, 2 = random ready.
    // start_at >= 0 pulses a stray start mid-stream; abort_at >= 0 resets while stalled on that beat.
    task automatic run_stream(input string name, input int len, input int ia, input bit two,
                              input int ib, input logic [3:0] ma, input logic [3:0] mb,
                              input int mode, input int start_at, input int abort_at,
                              output logic [3:0] first_beat);
        int         idx, valid_cycles, stall_n;
        bit         stalled, fin, r;
        logic [3:0] prev, exp;
        idx = 0; valid_cycles = 0; stall_n = 0; stalled = 0; fin = 0;
        prev = '0; first_beat = '0;
        apply_cfg(len, ia, two, ib, ma, mb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Live config wanders once the stream is launched; only the latched copy may matter.
        apply_cfg($urandom, $urandom, 1'($urandom), $urandom, 4'($urandom), 4'($urandom));
        n_checks++;
        if (busy !== 1'b1 || push_valid !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || beat_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s check_cycle: busy=%b valid=%b done=%b err=%b cnt=%0d, want 1 0 0 0 0",
                     name, busy, push_valid, done, cfg_err, beat_cnt);
        end
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == start_at) start = 1'b1;
            if (push_valid) begin
                valid_cycles++;
                if (stalled) begin
                    n_checks++;
                    if (push_data !== prev) begin
                        n_fail++;
                        $display("FAIL %s stall_hold beat%0d: data=%h, want held %h", name, idx, push_data, prev);
                    end
                end
                n_checks++;
                if (beat_cnt !== CW'(idx)) begin
                    n_fail++;
                    $display("FAIL %s beat_cnt: got %0d, want %0d", name, beat_cnt, idx);
                end
                if (abort_at == idx) begin
                    push_ready = 1'b0;
                    stall_n++;
                    if (stall_n == 3) begin
                        #2 rstn = 1'b0;
                        #1;
                        n_checks++;
                        if (push_valid !== 1'b0 || push_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
                            cfg_err !== 1'b0 || beat_cnt !== '0) begin
                            n_fail++;
                            $display("FAIL %s async_reset: valid=%b data=%h busy=%b done=%b err=%b cnt=%0d, want all 0",
                                     name, push_valid, push_data, busy, done, cfg_err, beat_cnt);
                        end
                        @(posedge clk); #1;
                        rstn = 1'b1;
                        mdl_pos = 0;
                        @(posedge clk); #1;
                        n_checks++;
                        if (push_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== '0) begin
                            n_fail++;
                            $display("FAIL %s post_reset_idle: valid=%b busy=%b done=%b cnt=%0d, want 0 0 0 0",
                                     name, push_valid, busy, done, beat_cnt);
                        end
                        fin = 1;
                    end
                    stalled = 1;
                    prev = push_data;
                end else begin
                    case (mode)
                        0:       r = 1'b1;
                        1:       r = (cyc % 3 == 0);
                        default: r = 1'($urandom);
                    endcase
                    push_ready = r;
                    if (r) begin
                        if (idx == ia) exp = ma;
                        else if (two && idx == ib) exp = mb;
                        else begin
                            exp = mdl_filler(ma, mb);
                            mdl_pos++;
                        end
                        n_checks++;
                        if (push_data !== exp) begin
                            n_fail++;
                            $display("FAIL %s beat%0d: data=%h, want %h", name, idx, push_data, exp);
                        end
                        if (idx == 0) first_beat = push_data;
                        idx++;
                    end
                    stalled = !r;
                    prev = push_data;
                end
            end else begin
                fin = 1;
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0 || idx != len || beat_cnt !== CW'(len)) begin
                    n_fail++;
                    $display("FAIL %s stream_end: done=%b busy=%b err=%b beats=%0d cnt=%0d, want 1 0 0 %0d %0d",
                             name, done, busy, cfg_err, idx, beat_cnt, len, len);
                end
            end
        end
        push_ready = 1'b0;
        start = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: stream did not finish, beats=%0d of %0d", name, idx, len);
        end
        if (mode == 0 && abort_at < 0) begin
            n_checks++;
            if (valid_cycles != len) begin
                n_fail++;
                $display("FAIL %s throughput: %0d valid cycles, want %0d", name, valid_cycles, len);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (push_valid !== 1'b0 || push_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            cfg_err !== 1'b0 || beat_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b data=%h busy=%b done=%b err=%b cnt=%0d, want all 0",
                     push_valid, push_data, busy, done, cfg_err, beat_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (push_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b done=%b, want 0 0 0", push_valid, busy, done);
        end
    endtask

    task automatic test_illegal(input string name, input int len, input int ia, input bit two,
                                input int ib, input logic [3:0] ma, input logic [3:0] mb);
        bit seen_valid;
        seen_valid = 0;
        apply_cfg(len, ia, two, ib, ma, mb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push_valid) seen_valid = 1;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0 || beat_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s illegal_done: done=%b err=%b busy=%b cnt=%0d, want 1 1 0 0",
                     name, done, cfg_err, busy, beat_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            if (push_valid) seen_valid = 1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL %s illegal_no_beat: push_valid was 1, want never", name);
        end
    endtask

    task automatic test_single_marker();
        logic [3:0] fb;
        run_stream("single_mark", 5, 2, 1'b0, 0, 4'hA, 4'hA, 0, -1, -1, fb);
    endtask

    task automatic test_two_marker_stall();
        logic [3:0] fb;
        run_stream("two_mark_stall", 6, 1, 1'b1, 4, 4'h3, 4'h5, 1, -1, -1, fb);
    endtask

    task automatic test_filler_collision();
        logic [3:0] l, fb;
        l = lfsr_seq[mdl_pos % 15];
        run_stream("collide_l2", 4, 2, 1'b1, 3, l, l ^ 4'd1, 0, -1, -1, fb);
        n_checks++;
        if (fb !== (l ^ 4'd2)) begin
            n_fail++;
            $display("FAIL collide_l2 first_filler: got %h, want %h", fb, l ^ 4'd2);
        end
        l = lfsr_seq[mdl_pos % 15];
        run_stream("collide_l1", 4, 2, 1'b0, 0, l, l, 0, -1, -1, fb);
        n_checks++;
        if (fb !== (l ^ 4'd1)) begin
            n_fail++;
            $display("FAIL collide_l1 first_filler: got %h, want %h", fb, l ^ 4'd1);
        end
    endtask

    task automatic test_illegal_configs();
        test_illegal("len_zero", 0, 0, 1'b0, 0, 4'h1, 4'h2);
        test_illegal("idx_a_eq_len", 5, 5, 1'b0, 0, 4'h1, 4'h2);
        test_illegal("idx_b_eq_idx_a", 5, 2, 1'b1, 2, 4'h1, 4'h2);
        test_illegal("idx_b_lt_idx_a", 5, 3, 1'b1, 1, 4'h1, 4'h2);
        test_illegal("idx_b_ge_len", 5, 1, 1'b1, 5, 4'h1, 4'h2);
        test_illegal("mark_b_eq_mark_a", 5, 1, 1'b1, 3, 4'h7, 4'h7);
    endtask

    task automatic test_abort();
        logic [3:0] fb;
        run_stream("abort", 8, 5, 1'b1, 6, 4'h9, 4'h4, 0, -1, 3, fb);
        run_stream("replay", 8, 5, 1'b1, 6, 4'h9, 4'h4, 0, -1, -1, fb);
        n_checks++;
        if (fb !== mdl_filler_at_seed(4'h9, 4'h4)) begin
            n_fail++;
            $display("FAIL replay first_beat: got %h, want %h", fb, mdl_filler_at_seed(4'h9, 4'h4));
        end
    endtask

    function automatic logic [3:0] mdl_filler_at_seed(input logic [3:0] ma, input logic [3:0] mb);
        logic [3:0] l;
        l = lfsr_seq[0];
        if (l != ma && l != mb) return l;
        if ((l ^ 4'd1) != ma && (l ^ 4'd1) != mb) return l ^ 4'd1;
        return l ^ 4'd2;
    endfunction

    task automatic test_ignored_start();
        logic [3:0] fb;
        run_stream("ignored_start", 7, 2, 1'b1, 5, 4'hB, 4'h0, 0, 2, -1, fb);
        run_stream("ignored_start_stall", 7, 0, 1'b1, 6, 4'h2, 4'hD, 1, 4, -1, fb);
    endtask

    task automatic test_random();
        logic [3:0] fb, ma, mb;
        int         len, ia, ib;
        bit         two;
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, 12);
            ia  = $urandom_range(0, len - 1);
            two = (ia < len - 1) && 1'($urandom);
            ib  = two ? $urandom_range(ia + 1, len - 1) : 0;
            ma  = 4'($urandom);
            mb  = two ? (ma ^ 4'($urandom_range(1, 15))) : ma;
            run_stream("random", len, ia, two, ib, ma, mb, 2, -1, -1, fb);
        end
    endtask

    initial begin
        test_reset();
        test_single_marker();
        test_two_marker_stall();
        test_filler_collision();
        test_illegal_configs();
        test_ignored_start();
        test_random();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fv_sb_wolper_src.md
Name: fv_sb_wolper_src

Overview:
- Synthesizable stimulus transmitter that drives the push side of a DUT checked by the team's Wolper data-integrity scoreboard.
- Emits a bounded stream of beats. Marker value A appears exactly once. Optional marker B appears exactly once, strictly after A.
- Every other beat is filler guaranteed distinct from both markers.
- Lets simulation benches and formal harnesses produce Wolper-legal traffic under valid/ready backpressure, without assumptions on push_data.

Parameters:
- DWIDTH, 4, payload width; must be >= 2.
- CWIDTH, 8, width of the stream length and beat-index counters.
- LFSR_SEED, 1, nonzero reset seed of the filler LFSR (DWIDTH bits).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; launches a stream when the block is IDLE or DONE
- cfg_len  in  CWIDTH  number of beats in the stream; must be >= 1
- cfg_idx_a  in  CWIDTH  beat index (0-based) that carries marker A
- cfg_two_mark  in  1  1 = also emit marker B
- cfg_idx_b  in  CWIDTH  beat index that carries marker B
- cfg_mark_a  in  DWIDTH  marker A value
- cfg_mark_b  in  DWIDTH  marker B value
- push_valid  out  1  beat valid toward the DUT
- push_ready  in  1  DUT accepts the beat
- push_data  out  DWIDTH  beat payload
- busy  out  1  high while a stream is in progress
- done  out  1  high in DONE; cleared by the next start
- cfg_err  out  1  latched illegal-configuration flag; cleared by the next start
- beat_cnt  out  CWIDTH  number of beats accepted in the current stream

Behaviour:
- Reset values: push_valid=0, push_data=0, busy=0, done=0, cfg_err=0, beat_cnt=0, FSM=IDLE, LFSR=LFSR_SEED.
- FSM states: IDLE, CHECK, SEND, DONE.
- IDLE/DONE + start → CHECK, on the next edge.
  - All cfg_* inputs are latched at this edge.
  - done, cfg_err and beat_cnt are cleared.
  - start in any other state is ignored.
- CHECK (exactly one cycle) flags the config as illegal if any of these hold:
  - cfg_len==0
  - idx_a >= len
  - two_mark and (idx_b >= len, or idx_b <= idx_a, or mark_b==mark_a)
- CHECK exits:
  - illegal → DONE with cfg_err=1; no beat is ever issued.
  - legal → SEND with push_valid=1, beat 0 presented.
- SEND handshake:
  - push_data and push_valid stay stable while push_valid && !push_ready.
  - A beat is accepted on a cycle with push_valid && push_ready.
  - On acceptance beat_cnt increments, and the next beat is presented the following cycle with no bubble.
  - Throughput is 1 beat/cycle under continuous ready.
- Payload of beat index i (i = beat_cnt when the beat is presented):
  - i==idx_a → mark_a.
  - two_mark && i==idx_b → mark_b.
  - Otherwise filler f, chosen as the first of {L, L^1, L^2} that equals neither marker (L = current LFSR value). One of the three always qualifies because there are only two markers.
- LFSR:
  - Maximal-length Galois, DWIDTH bits.
  - Advances only on acceptance of a filler beat, so stalls and marker beats do not change it.
  - Not reseeded by start; it is reseeded only by reset.
- Last beat: acceptance of beat len-1 → DONE on the next edge. Same edge: push_valid=0, busy=0, done=1.
- busy = 1 in CHECK and SEND.
- Reset asserted mid-stream: all state returns to reset values asynchronously. The partially sent stream is abandoned and no further beats are issued.
- cfg_* inputs changing while busy: no effect, since the latched copies are used.
- beat_cnt saturates at len; it never wraps inside a stream.

Decomposition:
- Package fv_sb_pkg holds:
  - FSM state enum (IDLE, CHECK, SEND, DONE).
  - LFSR tap-mask constant function indexed by DWIDTH, covering 2..16.
  - Shared DWIDTH/CWIDTH defaults.
- One natural sub-module, fv_sb_lfsr:
  - Inputs: clk, rstn, advance enable.
  - Output: state.
  - Seed parameter.
- Filler substitution and the FSM stay in the top.

Test Plan:
- DWIDTH=4, len=5, idx_a=2, mark_a=4'hA, two_mark=0, push_ready=1 → 5 consecutive beats; beat 2 = 4'hA; beats 0,1,3,4 ≠ 4'hA; done rises on the cycle after beat 4; beat_cnt=5.
- len=6, idx_a=1 (A=4'h3), idx_b=4 (B=4'h5), two_mark=1, push_ready toggling 1,0,0,1,… → push_data stable during every stall; 4'h3 only at beat 1; 4'h5 only at beat 4; no filler equals 4'h3 or 4'h5.
- Force LFSR to produce a value equal to mark_a at a filler slot (choose seed accordingly) → emitted value is L^1, or L^2 if L^1 equals mark_b; LFSR advances exactly once.
- Illegal configs, one per start: len=0; idx_a=len; two_mark=1 with idx_b==idx_a → cfg_err=1, done=1 two cycles after start, push_valid never asserted.
- rstn deasserted while stalled on beat 3 of 8 → push_valid=0 asynchronously; after release the block is IDLE with outputs at reset values, and the next start replays from beat 0.
- start pulsed during SEND → ignored; stream length and marker positions unchanged; beat_cnt continues monotonically.
